// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the M-stage store path and the DM write port,
// with per-lane forwarding to loads. Define STORE_BUFFER_MERGE_EN to merge same-word stores.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_data,
  input  logic [31:0] st_pc,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic [3:0]  fwd_be,
  output logic [31:0] fwd_data,
  input  logic        dm_busy,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_data,
  output logic [31:0] dm_pc,
  output logic        empty
);

  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [29:0]      tag_r   [DEPTH];
  logic [3:0]       be_r    [DEPTH];
  logic [31:0]      data_r  [DEPTH];
  logic [31:0]      pc_r    [DEPTH];
  logic             valid_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;

  logic             dm_we_s;
  logic             full_s;
  logic             merge_hit_s;
  logic             merge_s;
  logic             alloc_s;
  logic [PTR_W-1:0] last_s;
  logic [31:0]      merge_data_s;
  logic [3:0]       fwd_be_s;
  logic [31:0]      fwd_data_s;

  assign full_s  = (count_r == FULL_CNT);
  assign dm_we_s = (count_r != {(PTR_W+1){1'b0}}) && !dm_busy;
  assign last_s  = tail_r - PTR_ONE;

`ifdef STORE_BUFFER_MERGE_EN
  // Merge target is the youngest entry, unless it is the head leaving this cycle.
  always_comb begin
    merge_hit_s = 1'b0;
    if ((count_r != {(PTR_W+1){1'b0}}) && valid_r[last_s] &&
        (tag_r[last_s] == st_addr[31:2]) && !((last_s == head_r) && dm_we_s)) begin
      merge_hit_s = 1'b1;
    end else begin
      merge_hit_s = 1'b0;
    end
  end
`else
  assign merge_hit_s = 1'b0;
`endif

  assign st_ready = !full_s || merge_hit_s;
  assign merge_s  = st_valid && merge_hit_s;
  assign alloc_s  = st_valid && st_ready && !merge_hit_s;

  // Lane-wise overlay of the incoming store onto the merge target.
  always_comb begin
    merge_data_s = data_r[last_s];
    for (int b = 0; b < 4; b++) begin
      if (st_be[b]) begin
        merge_data_s[8*b +: 8] = st_data[8*b +: 8];
      end else begin
        merge_data_s[8*b +: 8] = data_r[last_s][8*b +: 8];
      end
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        tag_r[i]   <= 30'h0;
        be_r[i]    <= 4'h0;
        data_r[i]  <= 32'h0;
        pc_r[i]    <= 32'h0;
      end
    end else begin
      if (alloc_s) begin
        tag_r[tail_r]   <= st_addr[31:2];
        be_r[tail_r]    <= st_be;
        data_r[tail_r]  <= st_data;
        pc_r[tail_r]    <= st_pc;
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + PTR_ONE;
      end
      if (merge_s) begin
        be_r[last_s]   <= be_r[last_s] | st_be;
        data_r[last_s] <= merge_data_s;
        pc_r[last_s]   <= st_pc;
      end
      if (dm_we_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PTR_ONE;
      end
      case ({alloc_s, dm_we_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Walk oldest to youngest so younger matching lanes overwrite older ones.
  always_comb begin
    fwd_be_s   = 4'b0000;
    fwd_data_s = 32'h0;
    for (int k = 0; k < DEPTH; k++) begin : fwd_scan
      logic [PTR_W-1:0] idx;
      idx = head_r + PTR_W'(k);
      if (ld_valid && valid_r[idx] && (tag_r[idx] == ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (be_r[idx][b]) begin
            fwd_be_s[b]          = 1'b1;
            fwd_data_s[8*b +: 8] = data_r[idx][8*b +: 8];
          end else begin
            fwd_be_s[b]          = fwd_be_s[b];
            fwd_data_s[8*b +: 8] = fwd_data_s[8*b +: 8];
          end
        end
      end else begin
        fwd_be_s   = fwd_be_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  assign fwd_be   = fwd_be_s;
  assign fwd_data = fwd_data_s;
  assign dm_we    = dm_we_s;
  assign dm_addr  = {tag_r[head_r], 2'b00};
  assign dm_be    = be_r[head_r];
  assign dm_data  = data_r[head_r];
  assign dm_pc    = pc_r[head_r];
  assign empty    = (count_r == {(PTR_W+1){1'b0}});

endmodule
